// File: rtl/alarm_ringer_pkg.sv
// alarm_ringer_pkg: shared clock constants, ringer state encoding and default durations
package alarm_ringer_pkg;
  localparam int HR_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int RING_SEC_DEF = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/alarm_ringer_if.sv
// alarm_ringer_if: alarm inputs and ringer status outputs
interface alarm_ringer_if;
  logic tick_1hz;
  logic alarm_flag;
  logic alarm_en;
  logic snooze_btn;
  logic stop_btn;
  logic buzzer;
  logic ringing;
  logic snoozed;
  logic [1:0] snooze_used;
  modport master (
    output tick_1hz, alarm_flag, alarm_en, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozed, snooze_used
  );
  modport slave (
    input  tick_1hz, alarm_flag, alarm_en, snooze_btn, stop_btn,
    output buzzer, ringing, snoozed, snooze_used
  );
endinterface

// File: rtl/alarm_ringer_rise_detect.sv
// alarm_ringer_rise_detect: registered rising-edge detector, blind to a level already high at reset
module alarm_ringer_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic d_q, d_d, armed_q, armed_d;
  always_comb begin
    d_d = din;
    armed_d = armed_q | ~din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
      armed_q <= ~din;
    end else begin
      d_q <= d_d;
      armed_q <= armed_d;
    end
  end
  // armed_q stays low until the input is seen low, so a level held across reset is no edge
  assign rise = din & ~d_q & armed_q;
endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer: turns the alarm comparator flag into a timed ring/snooze session
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int RING_SEC = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input logic clk,
  input logic reset,
  alarm_ringer_if.slave bus
);
  localparam int CW = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_SEC);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [1:0] MAX_SN = 2'(MAX_SNOOZE);
  state_e state_q, state_d;
  logic [CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0] snooze_used_q, snooze_used_d;
  logic beep_q, beep_d, buzzer_q, buzzer_d;
  logic trig;
  logic tick_ok;
  alarm_ringer_rise_detect u_flag_rise (
    .clk(clk),
    .reset(reset),
    .din(bus.alarm_flag),
    .rise(trig)
  );
  assign tick_ok = bus.tick_1hz && sec_cnt_q != '0;
  always_comb begin
    state_d = state_q;
    sec_cnt_d = sec_cnt_q;
    snooze_used_d = snooze_used_q;
    beep_d = beep_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig && bus.alarm_en) begin
          state_d = ST_RING;
          sec_cnt_d = RING_LD;
          snooze_used_d = '0;
          beep_d = 1'b1;
        end
      end
      ST_RING: begin
        if (!bus.alarm_en || bus.stop_btn) state_d = ST_IDLE;
        else if (bus.snooze_btn && snooze_used_q < MAX_SN) begin
          state_d = ST_SNOOZE;
          sec_cnt_d = SNOOZE_LD;
          snooze_used_d = snooze_used_q + 2'd1;
          beep_d = 1'b0;
        end else if (tick_ok) begin
          sec_cnt_d = sec_cnt_q - ONE;
          beep_d = ~beep_q;
          state_d = sec_cnt_q == ONE ? ST_IDLE : ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (!bus.alarm_en || bus.stop_btn) state_d = ST_IDLE;
        else if (tick_ok) begin
          state_d = sec_cnt_q == ONE ? ST_RING : ST_SNOOZE;
          sec_cnt_d = sec_cnt_q == ONE ? RING_LD : sec_cnt_q - ONE;
          beep_d = sec_cnt_q == ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // snooze_used is kept in IDLE so the last event's count stays visible
    if (state_d == ST_IDLE) begin
      sec_cnt_d = '0;
      beep_d = 1'b0;
    end
    buzzer_d = state_d == ST_RING && beep_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sec_cnt_q <= '0;
      snooze_used_q <= '0;
      beep_q <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_cnt_q <= sec_cnt_d;
      snooze_used_q <= snooze_used_d;
      beep_q <= beep_d;
      buzzer_q <= buzzer_d;
    end
  end
  assign bus.ringing = state_q == ST_RING;
  assign bus.snoozed = state_q == ST_SNOOZE;
  assign bus.buzzer = buzzer_q;
  assign bus.snooze_used = snooze_used_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: scoreboard bench for alarm_ringer with a cycle reference model
module tb_alarm_ringer;
  localparam int RS = 4, SS = 3, MS = 2;
  typedef struct packed {
    logic ringing;
    logic snoozed;
    logic buzzer;
    logic [1:0] used;
  } out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  alarm_ringer_if bus();
  alarm_ringer #(.RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, tick_ph = 0;
  int ring_rise = 0, buzz_rise = 0;
  bit last_tick = 0;
  out_t cur = '0;
  out_t exp_q[$];
  int m_st = 0, m_cnt = 0, m_used = 0;
  bit m_beep = 0, m_fd = 0, m_armed = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model(output out_t e);
    bit trig;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_used = 0; m_beep = 0; m_fd = 0;
      m_armed = !bus.alarm_flag;
    end else begin
      trig = bus.alarm_flag && !m_fd && m_armed;
      m_armed = m_armed || !bus.alarm_flag;
      m_fd = bus.alarm_flag;
      if (m_st == 0) begin
        if (trig && bus.alarm_en) begin m_st = 1; m_cnt = RS; m_used = 0; m_beep = 1; end
      end else if (!bus.alarm_en || bus.stop_btn) m_st = 0;
      else if (m_st == 1 && bus.snooze_btn && m_used < MS) begin
        m_st = 2; m_cnt = SS; m_used++; m_beep = 0;
      end else if (bus.tick_1hz) begin
        m_cnt--;
        if (m_st == 1) begin
          m_beep = !m_beep;
          if (m_cnt == 0) m_st = 0;
        end else if (m_cnt == 0) begin
          m_st = 1; m_cnt = RS; m_beep = 1;
        end
      end
      if (m_st == 0) begin m_cnt = 0; m_beep = 0; end
    end
    e = {m_st == 1, m_st == 2, m_st == 1 && m_beep, 2'(m_used)};
  endtask
  task automatic step(input string tag);
    out_t e, prev;
    bus.tick_1hz = tick_ph == 9;
    last_tick = bus.tick_1hz;
    tick_ph = (tick_ph + 1) % 10;
    model(e);
    exp_q.push_back(e);
    prev = cur;
    @(posedge clk);
    #1;
    cur = {bus.ringing, bus.snoozed, bus.buzzer, bus.snooze_used};
    check(tag, 32'(cur), 32'(exp_q.pop_front()));
    ring_rise += int'(cur.ringing && !prev.ringing);
    buzz_rise += int'(cur.buzzer && !prev.buzzer);
    bus.snooze_btn = 1'b0;
    bus.stop_btn = 1'b0;
  endtask
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask
  task automatic ticks(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < 10 * n + 20 && seen < n; i++) begin
      step(tag);
      seen += int'(last_tick);
    end
    if (seen < n) check({tag, "_timeout"}, 32'(seen), 32'(n));
  endtask
  task automatic ring_up(input string tag);
    bus.alarm_flag = 1'b1;
    step(tag);
    bus.alarm_flag = 1'b0;
    check({tag, "_ring"}, 32'(cur.ringing), 32'd1);
  endtask
  initial begin
    bus.tick_1hz = 0; bus.alarm_flag = 0; bus.alarm_en = 0;
    bus.snooze_btn = 0; bus.stop_btn = 0;
    run(3, "reset");
    check("reset_outs", 32'(cur), 32'd0);
    reset = 1'b0;
    bus.alarm_en = 1'b1;
    // 1: held flag gives one full session with alternating beep
    ring_rise = 0; buzz_rise = 0;
    bus.alarm_flag = 1'b1;
    step("t1");
    check("t1_start", {30'd0, cur.ringing, cur.buzzer}, 32'd3);
    run(9, "t1_hold");
    bus.alarm_flag = 1'b0;
    run(45, "t1");
    check("t1_sessions", 32'(ring_rise), 32'd1);
    check("t1_beeps", 32'(buzz_rise), 32'd2);
    check("t1_idle", 32'(cur), 32'd0);
    // 2: snooze after first tick, re-ring after SS ticks
    ring_up("t2");
    ticks(1, "t2_tick1");
    bus.snooze_btn = 1'b1;
    step("t2_snz");
    check("t2_snoozed", 32'(cur), 32'(out_t'{1'b0, 1'b1, 1'b0, 2'd1}));
    ticks(SS, "t2_wait");
    check("t2_rering", {30'd0, cur.ringing, cur.buzzer}, 32'd3);
    bus.stop_btn = 1'b1;
    step("t2_stop");
    // 3: snooze limit
    ring_up("t3");
    bus.snooze_btn = 1'b1;
    step("t3_snz1");
    ticks(SS, "t3_w1");
    bus.snooze_btn = 1'b1;
    step("t3_snz2");
    ticks(SS, "t3_w2");
    bus.snooze_btn = 1'b1;
    step("t3_snz3");
    check("t3_ignored", 32'(cur), 32'(out_t'{1'b1, 1'b0, 1'b1, 2'd2}));
    bus.stop_btn = 1'b1;
    step("t3_stop");
    check("t3_idle", 32'(cur), 32'(out_t'{1'b0, 1'b0, 1'b0, 2'd2}));
    // 4: stop beats snooze
    ring_up("t4");
    bus.snooze_btn = 1'b1;
    step("t4_snz");
    ticks(SS, "t4_w");
    bus.snooze_btn = 1'b1;
    bus.stop_btn = 1'b1;
    step("t4_both");
    check("t4_idle", 32'(cur), 32'(out_t'{1'b0, 1'b0, 1'b0, 2'd1}));
    // 5: enable drop in snooze, and a flag edge lost while disabled
    ring_up("t5");
    bus.snooze_btn = 1'b1;
    step("t5_snz");
    run(2, "t5");
    bus.alarm_en = 1'b0;
    step("t5_off");
    check("t5_idle", 32'(cur), 32'(out_t'{1'b0, 1'b0, 1'b0, 2'd1}));
    bus.alarm_flag = 1'b1;
    step("t5_flag");
    bus.alarm_en = 1'b1;
    run(5, "t5_late_en");
    check("t5_noring", 32'(cur.ringing), 32'd0);
    bus.alarm_flag = 1'b0;
    step("t5");
    // 6: reset mid-ring with the flag still high
    bus.alarm_flag = 1'b1;
    step("t6");
    run(3, "t6_ring");
    reset = 1'b1;
    step("t6_rst");
    check("t6_rst_outs", 32'(cur), 32'd0);
    reset = 1'b0;
    run(6, "t6_held");
    check("t6_noretrig", 32'(cur.ringing), 32'd0);
    bus.alarm_flag = 1'b0;
    step("t6_low");
    bus.alarm_flag = 1'b1;
    step("t6_rise");
    check("t6_retrig", 32'(cur.ringing), 32'd1);
    bus.alarm_flag = 1'b0;
    run(50, "t6_tail");
    check("t6_end", 32'(cur.ringing), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
